// File: rtl/sw_debounce_pkg.sv
// Shared switch-path constants for the debounce filter and the switch bus controller.
// Both sides take the vector width and default debounce length from here.
package sw_debounce_pkg;

    localparam int SW_WIDTH            = 16;
    localparam int SW_DEBOUNCE_DEFAULT = 100000;

    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sw_debounce_filter_bit.sv
// One switch bit: two-flop synchronizer, saturating agreement counter, stable level.
// update_o flags the edge on which the stable level is about to take the synced value.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o,
    output logic update_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ;

    assign differ   = (sync2_q != stable_q);
    assign update_o = differ && (cnt_q == CNT_MAX);

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (update_o) begin
            stable_d = sync2_q;
        end else if (differ) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/sw_debounce_filter.sv
// Debounced switch vector with change strobe and sticky interrupt request.
// Interrupt flop exists only when SW_DEBOUNCE_IRQ_EN is defined; otherwise irq_o is 0.
module sw_debounce_filter
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic             sw_changed_o,
    output logic             irq_o,
    input  logic             irq_ret_i
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] update;
    logic             any_update;
    logic             changed_q;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .raw_i   (sw_raw_i[b]),
            .stable_o(sw_o[b]),
            .update_o(update[b])
        );
    end

    assign any_update = |update;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= any_update;
        end
    end

    assign sw_changed_o = changed_q;

`ifdef SW_DEBOUNCE_IRQ_EN
    logic irq_q, irq_d;

    // A new change outranks a same-edge acknowledge.
    always_comb begin
        irq_d = irq_q;
        if (any_update) begin
            irq_d = 1'b1;
        end else if (irq_ret_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_ret;
    assign unused_irq_ret = irq_ret_i;
    assign irq_o          = 1'b0;
`endif

endmodule

// File: doc/sw_debounce_filter.md
Name: sw_debounce_filter

Overview:
- Conditions the 16 raw board switch levels before they reach the switch system-bus controller, which drives them onto RD_o[15:0].
- Per bit: 2-FF synchronizer, then a saturating-count debouncer.
- Outputs a stable switch vector, a one-cycle change strobe, and an optional sticky interrupt request with return handshake to the core's interrupt controller.

Parameters:
- WIDTH, 16, number of switch bits.
- DEBOUNCE_CYCLES, 100000, consecutive cycles a synchronized level must differ from the stable level before it is accepted. Legal values ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-bit counter. Derived; do not override.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset: asynchronous, active-high
- sw_raw_i  input  WIDTH  raw switch pins, asynchronous to clk_i
- sw_o  output  WIDTH  debounced stable switch levels; feeds sw_i of the switch bus controller
- sw_changed_o  output  1  one-cycle pulse, any bit of sw_o changed
- irq_o  output  1  interrupt request, sticky
- irq_ret_i  input  1  interrupt return/acknowledge from the interrupt controller

Behaviour:
- Reset (async assert, sync release):
  - sync stages = 0, stable = 0, counters = 0.
  - sw_o = 0, sw_changed_o = 0, irq_o = 0.
- Synchronizer: sync1 <= sw_raw_i, then sync2 <= sync1. Per-bit, no cross-bit coherence guaranteed.
- Per-bit debouncer, each rising edge:
  - sync2 == stable: cnt <= 0.
  - sync2 != stable and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
- Latency: for a raw level held constant, sw_o updates on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new level as edge 1.
- Glitch rejection: a raw pulse whose synchronized image lasts fewer than DEBOUNCE_CYCLES cycles never reaches sw_o. Its counter returns to 0 when the level returns.
- Counter never exceeds DEBOUNCE_CYCLES-1. No wrap-around.
- sw_o = stable register. Registered output, no combinational path from sw_raw_i.
- sw_changed_o: registered. High for exactly one cycle, on the edge where ≥1 stable bit updates, so it is coincident with the new sw_o value. Multiple bits updating on the same edge give one pulse.
- irq_o (with feature):
  - Set on any edge that raises sw_changed_o.
  - Cleared on an edge with irq_ret_i=1 and no new change.
  - Change and irq_ret_i on the same edge: irq_o stays 1 (set wins).
  - irq_ret_i while irq_o=0: no effect.
- Reset mid-debounce: all progress discarded. After release, a held raw level needs the full DEBOUNCE_CYCLES+2 latency again.

Optional Feature:
- Macro: SW_DEBOUNCE_IRQ_EN.
- Defined: irq_o / irq_ret_i behave as above.
- Undefined:
  - irq_o tied 0, irq_ret_i ignored, no irq flop.
  - Ports remain present so top-level wiring is unchanged.
  - sw_o and sw_changed_o behaviour is identical either way.

Decomposition:
- Shared package: SW_WIDTH = 16 and the default debounce constant, so the switch controller and top level share one definition.
- One natural sub-module: sw_debounce_bit, a 1-bit synchronizer + counter + stable register with an "update" output. Generated WIDTH times.
- Parent ORs the update outputs into sw_changed_o and owns the irq flop.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset: hold rst_i=1 with sw_raw_i=16'hFFFF → sw_o=0, sw_changed_o=0, irq_o=0 throughout. Release and hold 16'hFFFF → sw_o=16'hFFFF on edge 6 after release, sw_changed_o high that cycle only.
- Latency: step sw_raw_i 16'h0000→16'h00A5 → sw_o=16'h00A5 exactly 6 edges later. One sw_changed_o pulse; irq_o rises the same edge.
- Glitch: bit 3 high for 3 cycles then low → sw_o stays 16'h0000, no sw_changed_o. Bit 3 high for 4 synced cycles → accepted.
- Bounce: toggle bit 0 every 2 cycles for 20 cycles, then hold 1 → sw_o[0] changes once, 6 edges after the final transition.
- Interrupt handshake: irq_o=1, pulse irq_ret_i → irq_o=0 next edge. Repeat with irq_ret_i coincident with a new sw_changed_o → irq_o stays 1.
- Reset mid-operation: assert rst_i 2 cycles after a raw change → sw_o=0 immediately (async). After release, full 6-edge latency observed. Build without SW_DEBOUNCE_IRQ_EN → irq_o constantly 0.
